// File: rtl/qrisc32_wbuf.sv
// Posted write buffer for the qrisc32 data port: an in-order FIFO drains CPU writes to memory
// and holds back any CPU read that targets an address still waiting to be written.
module qrisc32_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          cpu_dataw_data,
  input  logic [AW-1:0]          cpu_dataw_addr,
  input  logic                   cpu_dataw_wr,
  output logic                   cpu_dataw_wait_req,
  input  logic [AW-1:0]          cpu_datar_addr,
  input  logic                   cpu_datar_rd,
  output logic [DW-1:0]          cpu_datar_data,
  output logic                   cpu_datar_wait_req,
  output logic [DW-1:0]          mem_dataw_data,
  output logic [AW-1:0]          mem_dataw_addr,
  output logic                   mem_dataw_wr,
  input  logic                   mem_dataw_wait_req,
  output logic [AW-1:0]          mem_datar_addr,
  output logic                   mem_datar_rd,
  input  logic [DW-1:0]          mem_datar_data,
  input  logic                   mem_datar_wait_req,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             hit;
  logic [DEPTH-1:0] entry_match;
  logic [PW-1:0]    offset;

  // Full is taken from the registered count, so a pop never frees a slot in its own cycle
  assign cpu_dataw_wait_req = (count == FULL_COUNT);
  assign push               = cpu_dataw_wr & ~cpu_dataw_wait_req;
  assign mem_dataw_wr       = (count != '0);
  assign pop                = mem_dataw_wr & ~mem_dataw_wait_req;
  assign mem_dataw_addr     = addr_q[head];
  assign mem_dataw_data     = data_q[head];
  assign wb_count           = count;
  assign wb_empty           = (count == '0);

  // Pointers are PW bits wide, so they wrap at DEPTH without an explicit modulo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_dataw_addr;
      data_q[tail] <= cpu_dataw_data;
    end
  end

  // An entry is live when its distance from head is below the occupancy
  always_comb begin
    entry_match = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - head;
      entry_match[i] = ({1'b0, offset} < count) && (addr_q[i] == cpu_datar_addr);
    end
  end

  assign hit = (|entry_match) | (push & (cpu_dataw_addr == cpu_datar_addr));

  assign mem_datar_addr     = cpu_datar_addr;
  assign cpu_datar_data     = mem_datar_data;
  assign mem_datar_rd       = cpu_datar_rd & ~hit;
  assign cpu_datar_wait_req = (cpu_datar_rd & hit) | mem_datar_wait_req;

endmodule

// File: doc/qrisc32_wbuf.md
Name: qrisc32_wbuf

Overview:
Posted write buffer between the qrisc32 data-write Avalon master and the system data memory. It accepts CPU writes into a small in-order FIFO and drains them to memory, so the MEM stage stalls only when the buffer is full. It also sits on the data-read path and blocks any CPU read whose address matches a pending write until that write has drained. This read-after-write protection preserves memory consistency.

Parameters:
DEPTH, 4, number of buffered write entries; power of two, minimum 2.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_dataw_data  input  DW  write data from CPU
cpu_dataw_addr  input  AW  write address from CPU
cpu_dataw_wr  input  1  CPU write request
cpu_dataw_wait_req  output  1  stall to CPU write port
cpu_datar_addr  input  AW  read address from CPU
cpu_datar_rd  input  1  CPU read request
cpu_datar_data  output  DW  read data to CPU
cpu_datar_wait_req  output  1  stall to CPU read port
mem_dataw_data  output  DW  write data to memory
mem_dataw_addr  output  AW  write address to memory
mem_dataw_wr  output  1  memory write request
mem_dataw_wait_req  input  1  memory write stall
mem_datar_addr  output  AW  read address to memory
mem_datar_rd  output  1  memory read request
mem_datar_data  input  DW  read data from memory
mem_datar_wait_req  input  1  memory read stall
wb_count  output  log2(DEPTH)+1  current occupancy
wb_empty  output  1  occupancy == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset clears the head pointer, the tail pointer and the count. Stored data is don't-care after reset.
- Outputs during and immediately after reset:
  - cpu_dataw_wait_req=0, mem_dataw_wr=0, wb_count=0, wb_empty=1.
  - The read path passes through (see below).
- Avalon transfer rule: a transfer completes on a cycle where the request is 1 and wait_req is 0. The requester holds address, data and request stable while wait_req is 1.
- Push: push = cpu_dataw_wr & ~cpu_dataw_wait_req. The entry is written at tail, and tail advances modulo DEPTH.
- Full flag: cpu_dataw_wait_req = (count == DEPTH). This is decoded from registered count only.
  - A pop in the same cycle does not free a slot that cycle.
  - A full buffer therefore accepts its next write at the earliest one cycle after a pop.
- Memory write side:
  - mem_dataw_wr = (count != 0). mem_dataw_addr and mem_dataw_data come from the head entry.
  - Pop = mem_dataw_wr & ~mem_dataw_wait_req. Head advances modulo DEPTH.
- Latency and ordering:
  - A write accepted at edge N is presented on the memory port from cycle N+1. There is no empty-buffer bypass.
  - Strict FIFO order is kept; writes are never merged.
- Count update:
  - Push without pop: count+1.
  - Pop without push: count-1.
  - Push and pop together: count unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Hazard detection: hit = 1 if cpu_datar_addr equals the address of any valid entry, or equals cpu_dataw_addr while push=1 in the same cycle. The compare is full-width AW.
- Read path:
  - mem_datar_addr = cpu_datar_addr (combinational).
  - cpu_datar_data = mem_datar_data (combinational).
  - When cpu_datar_rd & hit: mem_datar_rd=0 and cpu_datar_wait_req=1.
  - Otherwise: mem_datar_rd = cpu_datar_rd and cpu_datar_wait_req = mem_datar_wait_req.
- Hazard release: the blocked read is released on the cycle after the last matching entry pops. It then follows the normal pass-through rule.
- Reset mid-operation: pending writes are discarded. mem_dataw_wr drops to 0 asynchronously.

Test Plan:
1. Single write: DEPTH=4, mem_dataw_wait_req=0; write addr 0x100, data 0xDEADBEEF at cycle 0 -> mem_dataw_wr=1 for exactly cycle 1 with 0x100/0xDEADBEEF; wb_count 1 then 0; cpu_dataw_wait_req stays 0.
2. Fill and stall: mem_dataw_wait_req=1; CPU writes 0x10..0x14 back-to-back -> 4 accepted, wb_count=4, cpu_dataw_wait_req=1 holding 0x14. Release mem wait -> memory sees 0x10, 0x11, 0x12, 0x13, 0x14 in order, and 0x14 is accepted one cycle after the first pop.
3. RAW hazard: mem_dataw_wait_req=1, pending write to 0x200; read 0x200 -> mem_datar_rd=0, cpu_datar_wait_req=1. Release mem wait -> read forwarded the cycle after the pop. Read of 0x204 with the same entry pending -> forwarded immediately.
4. Same-cycle hazard: empty buffer; write 0x300 and read 0x300 in the same cycle -> the read is blocked until the 0x300 write pops.
5. Simultaneous push/pop and wrap: hold wb_count=2 with continuous push and pop over 12 writes -> wb_count constant at 2, pointers wrap, all 12 writes reach memory in order.
6. Reset mid-operation: 3 entries pending, assert reset asynchronously -> mem_dataw_wr=0 and wb_count=0 without waiting for a clock edge; no stale writes appear after reset deasserts.
